cpu_branch_resolve: RTL and testbench
=====================================

// Module: cpu_branch_resolve
// PURPOSE
//  Decode-side counterpart of cpu_fetch. Registers the instr/pc pair that fetch presents.
//  Resolves JAL, JALR and conditional branches against register-file operands.
//  Drives the one-cycle redirect controls (jal/jalr/branch/branch_taken/targets) back into fetch.
//  Squashes wrong-path instructions already in flight; surviving instructions pass on as id_*.
// PARAMETERS
//  XLEN           32  datapath / PC width
//  SQUASH_CYCLES  2   captures invalidated after a redirect; range 1..7, 3-bit counter
// PORTS
//  clk            in   1     rising-edge clock
//  reset          in   1     synchronous, active-high
//  instr          in   32    instruction from fetch
//  pc_in          in   XLEN  pc_out from fetch
//  rs1_data       in   XLEN  regfile read data for rs1_addr (combinational)
//  rs2_data       in   XLEN  regfile read data for rs2_addr (combinational)
//  rs1_addr       out  5     id_instr[19:15]
//  rs2_addr       out  5     id_instr[24:20]
//  id_instr       out  32    registered instruction
//  id_pc          out  XLEN  registered PC
//  id_valid       out  1     id_instr/id_pc belong to the correct path
//  jal            out  1     1-cycle pulse: JAL redirect, target on branch_target
//  jalr           out  1     1-cycle pulse: JALR redirect, target on jalr_target
//  branch         out  1     1-cycle pulse: conditional branch resolved
//  branch_taken   out  1     with branch: condition true, redirect to branch_target
//  branch_target  out  XLEN  JAL target or branch target
//  jalr_target    out  XLEN  JALR target
// BEHAVIOUR
//  Reset values:
//   - All outputs 0; id_valid=0.
//   - state=RUN; squash count=0.
//   - Reset mid-SQUASH aborts the squash and clears pending redirects.
//  Stage register:
//   - Every edge, id_instr<=instr and id_pc<=pc_in. There is no stall.
//   - id_valid<=1 in RUN.
//   - id_valid<=0 for each capture while in SQUASH, and on the capture made on the edge that issues a redirect.
//  Decode:
//   - Decode uses only id_instr, and only when id_valid=1 and state=RUN.
//   - opcode 1101111=JAL, 1100111=JALR, 1100011=BRANCH.
//  Target arithmetic (all mod 2^XLEN, imm sign-extended):
//   - JAL:    branch_target = id_pc + immJ
//   - JALR:   jalr_target   = (rs1_data + immI) & ~1
//   - BRANCH: branch_target = id_pc + immB
//  Branch condition, by funct3:
//   - 000 BEQ, 001 BNE
//   - 100 BLT, 101 BGE: signed compare
//   - 110 BLTU, 111 BGEU: unsigned compare
//   - 010/011: branch=1, branch_taken=0
//  Output timing:
//   - Control outputs are registered: asserted the cycle after the instruction sits in id_*.
//   - Each pulse is high for exactly 1 cycle, then returns to 0.
//   - Targets hold their last value.
//  FSM RUN -> SQUASH:
//   - Triggered when a redirect is issued: JAL, JALR, or a taken BRANCH.
//   - Counter loads SQUASH_CYCLES.
//  FSM SQUASH:
//   - Counter decrements each edge; id_valid held 0.
//   - Control decoded from id_instr is ignored: no pulses during SQUASH.
//   - Returns to RUN when count reaches 0.
//   - The next capture is the redirect target and is valid.
//  Not-taken branches:
//   - branch=1, branch_taken=0.
//   - No squash; id_valid stays 1 for following instructions.
//  Back-to-back control instructions: the second is on the wrong path and is suppressed.
// TESTING
//  1. JAL immJ=+0x20 at pc 0x0
//     -> jal=1, branch_target=0x20 for one cycle
//     -> next 2 captures id_valid=0; first valid id_pc=0x20
//  2. JALR rs1_data=0x3F, immI=+1 at pc 0x8
//     -> jalr=1, jalr_target=0x40; 2-cycle squash; id_pc=0x40
//  3. BEQ rs1=rs2=5, immB=+0x40 at pc 0x20
//     -> branch=1, branch_taken=1, branch_target=0x60; squash
//     With rs2=6 instead -> branch=1, branch_taken=0, no squash
//  4. Signedness, rs1=0xFFFFFFFF, rs2=1
//     -> BLT taken
//     -> BLTU not taken, id_valid stays 1
//  5. JAL immediately followed by BNE (taken operands)
//     -> only jal pulses; BNE captured with id_valid=0
//  6. reset asserted in cycle 1 of SQUASH
//     -> all outputs 0 next edge; RUN
//     -> first capture after release id_valid=1, no stale pulse

Source files
------------

// File: rtl/cpu_branch_resolve.sv
// Decode-side branch resolution: registers the fetch instr/pc pair, resolves JAL/JALR/branches,
// pulses redirect controls back to fetch, and squashes wrong-path captures after a redirect.
module cpu_branch_resolve #(
    parameter int XLEN          = 32,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc_in,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output logic [4:0]      o_rs1_addr,
    output logic [4:0]      o_rs2_addr,
    output logic [31:0]     o_id_instr,
    output logic [XLEN-1:0] o_id_pc,
    output logic            o_id_valid,
    output logic            o_jal,
    output logic            o_jalr,
    output logic            o_branch,
    output logic            o_branch_taken,
    output logic [XLEN-1:0] o_branch_target,
    output logic [XLEN-1:0] o_jalr_target,
    output logic            o_state,
    output logic [2:0]      o_squash_cnt
);

    typedef enum logic {ST_RUN = 1'b0, ST_SQUASH = 1'b1} state_t;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] SQ_LOAD   = 3'(SQUASH_CYCLES);

    state_t            r_state;
    logic [2:0]        r_squash_cnt;
    logic [31:0]       r_id_instr;
    logic [XLEN-1:0]   r_id_pc;
    logic              r_id_valid;
    logic              r_jal;
    logic              r_jalr;
    logic              r_branch;
    logic              r_branch_taken;
    logic [XLEN-1:0]   r_branch_target;
    logic [XLEN-1:0]   r_jalr_target;

    logic              w_decode_en;
    logic              w_is_jal;
    logic              w_is_jalr;
    logic              w_is_branch;
    logic              w_cond;
    logic              w_redirect;
    logic [XLEN-1:0]   w_imm_i;
    logic [XLEN-1:0]   w_imm_j;
    logic [XLEN-1:0]   w_imm_b;

    assign w_imm_i = {{(XLEN-12){r_id_instr[31]}}, r_id_instr[31:20]};
    assign w_imm_j = {{(XLEN-20){r_id_instr[31]}}, r_id_instr[19:12], r_id_instr[20],
                      r_id_instr[30:21], 1'b0};
    assign w_imm_b = {{(XLEN-12){r_id_instr[31]}}, r_id_instr[7], r_id_instr[30:25],
                      r_id_instr[11:8], 1'b0};

    // Only a valid instruction on the correct path may produce control effects.
    assign w_decode_en = r_id_valid && (r_state == ST_RUN);
    assign w_is_jal    = w_decode_en && (r_id_instr[6:0] == OP_JAL);
    assign w_is_jalr   = w_decode_en && (r_id_instr[6:0] == OP_JALR);
    assign w_is_branch = w_decode_en && (r_id_instr[6:0] == OP_BRANCH);

    always_comb begin
        w_cond = 1'b0;
        case (r_id_instr[14:12])
            3'b000:  w_cond = (i_rs1_data == i_rs2_data);
            3'b001:  w_cond = (i_rs1_data != i_rs2_data);
            3'b100:  w_cond = ($signed(i_rs1_data) <  $signed(i_rs2_data));
            3'b101:  w_cond = ($signed(i_rs1_data) >= $signed(i_rs2_data));
            3'b110:  w_cond = (i_rs1_data <  i_rs2_data);
            3'b111:  w_cond = (i_rs1_data >= i_rs2_data);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_redirect = w_is_jal || w_is_jalr || (w_is_branch && w_cond);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= ST_RUN;
            r_squash_cnt    <= 3'd0;
            r_id_instr      <= 32'd0;
            r_id_pc         <= '0;
            r_id_valid      <= 1'b0;
            r_jal           <= 1'b0;
            r_jalr          <= 1'b0;
            r_branch        <= 1'b0;
            r_branch_taken  <= 1'b0;
            r_branch_target <= '0;
            r_jalr_target   <= '0;
        end else begin
            r_id_instr     <= i_instr;
            r_id_pc        <= i_pc_in;
            r_jal          <= w_is_jal;
            r_jalr         <= w_is_jalr;
            r_branch       <= w_is_branch;
            r_branch_taken <= w_is_branch && w_cond;
            if (w_is_jal)
                r_branch_target <= r_id_pc + w_imm_j;
            else if (w_is_branch)
                r_branch_target <= r_id_pc + w_imm_b;
            if (w_is_jalr)
                r_jalr_target <= (i_rs1_data + w_imm_i) & ~{{(XLEN-1){1'b0}}, 1'b1};

            case (r_state)
                ST_RUN: begin
                    if (w_redirect) begin
                        r_state      <= ST_SQUASH;
                        r_squash_cnt <= SQ_LOAD;
                        r_id_valid   <= 1'b0;
                    end else begin
                        r_id_valid   <= 1'b1;
                    end
                end
                default: begin
                    // The capture on the edge that drains the counter is the redirect target.
                    r_squash_cnt <= r_squash_cnt - 3'd1;
                    if (r_squash_cnt == 3'd1) begin
                        r_state    <= ST_RUN;
                        r_id_valid <= 1'b1;
                    end else begin
                        r_id_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_rs1_addr      = r_id_instr[19:15];
    assign o_rs2_addr      = r_id_instr[24:20];
    assign o_id_instr      = r_id_instr;
    assign o_id_pc         = r_id_pc;
    assign o_id_valid      = r_id_valid;
    assign o_jal           = r_jal;
    assign o_jalr          = r_jalr;
    assign o_branch        = r_branch;
    assign o_branch_taken  = r_branch_taken;
    assign o_branch_target = r_branch_target;
    assign o_jalr_target   = r_jalr_target;
    assign o_state         = r_state;
    assign o_squash_cnt    = r_squash_cnt;

endmodule

// File: tb/tb_cpu_branch_resolve.sv
// Directed bench for cpu_branch_resolve: drives fetch-side instr/pc, models the regfile read
// ports, and checks redirect pulses, targets and the squash window against hand-computed values.
module tb_cpu_branch_resolve;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic            clk;
    logic            reset;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;
    logic            id_valid;
    logic            jal;
    logic            jalr;
    logic            branch;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jalr_target;
    logic            state;
    logic [2:0]      squash_cnt;

    logic [31:0] regs [32];
    int n_checks;
    int n_pass;

    cpu_branch_resolve #(.XLEN(XLEN), .SQUASH_CYCLES(2)) dut (
        .i_clk(clk), .i_reset(reset), .i_instr(instr), .i_pc_in(pc_in),
        .i_rs1_data(rs1_data), .i_rs2_data(rs2_data),
        .o_rs1_addr(rs1_addr), .o_rs2_addr(rs2_addr),
        .o_id_instr(id_instr), .o_id_pc(id_pc), .o_id_valid(id_valid),
        .o_jal(jal), .o_jalr(jalr), .o_branch(branch), .o_branch_taken(branch_taken),
        .o_branch_target(branch_target), .o_jalr_target(jalr_target),
        .o_state(state), .o_squash_cnt(squash_cnt)
    );

    // Combinational regfile read model.
    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic cycle(input logic [31:0] ins, input logic [31:0] pc);
        instr = ins;
        pc_in = pc;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] enc_jal(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, 5'd1, 7'b1100111};
    endfunction

    function automatic logic [31:0] enc_br(input logic [2:0] f3, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1] = 32'h0000_003F;
        regs[5] = 32'd5;
        regs[6] = 32'd5;
        regs[7] = 32'd6;
        regs[8] = 32'hFFFF_FFFF;
        regs[9] = 32'd1;
        instr = NOP;
        pc_in = 32'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_pulses", {28'd0, jal, jalr, branch, branch_taken}, 32'd0);
        check("rst_targets", branch_target | jalr_target, 32'd0);
        check("rst_state", {28'd0, state, squash_cnt}, 32'd0);
        reset = 1'b0;

        // JAL +0x20 at pc 0
        cycle(enc_jal(21'h20), 32'h0);
        check("jal_in_id_valid", {31'd0, id_valid}, 32'd1);
        check("jal_no_early_pulse", {31'd0, jal}, 32'd0);
        cycle(NOP, 32'h4);
        check("jal_pulse", {31'd0, jal}, 32'd1);
        check("jal_target", branch_target, 32'h20);
        check("jal_sq1_valid", {31'd0, id_valid}, 32'd0);
        check("jal_state", {31'd0, state}, 32'd1);
        cycle(NOP, 32'h8);
        check("jal_pulse_drop", {31'd0, jal}, 32'd0);
        check("jal_sq2_valid", {31'd0, id_valid}, 32'd0);
        cycle(NOP, 32'h20);
        check("jal_tgt_valid", {31'd0, id_valid}, 32'd1);
        check("jal_tgt_pc", id_pc, 32'h20);
        check("jal_target_hold", branch_target, 32'h20);

        // JALR x1(0x3F)+1 at pc 8
        cycle(enc_jalr(5'd1, 12'd1), 32'h8);
        cycle(NOP, 32'hC);
        check("jalr_pulse", {30'd0, jalr, jal}, 32'd2);
        check("jalr_target", jalr_target, 32'h40);
        check("jalr_sq1_valid", {31'd0, id_valid}, 32'd0);
        cycle(NOP, 32'h10);
        check("jalr_sq2_valid", {31'd0, id_valid}, 32'd0);
        cycle(NOP, 32'h40);
        check("jalr_tgt", {id_pc[30:0], id_valid}, {31'h40, 1'b1});

        // BEQ 5==5 +0x40 at 0x20 -> taken
        cycle(enc_br(3'b000, 5'd5, 5'd6, 13'h40), 32'h20);
        cycle(NOP, 32'h24);
        check("beq_t_flags", {30'd0, branch, branch_taken}, 32'd3);
        check("beq_t_target", branch_target, 32'h60);
        check("beq_t_sq_valid", {31'd0, id_valid}, 32'd0);
        cycle(NOP, 32'h28);
        cycle(NOP, 32'h60);
        check("beq_t_tgt", {id_pc[30:0], id_valid}, {31'h60, 1'b1});

        // BEQ 5 vs 6 at 0x60 -> not taken, no squash
        cycle(enc_br(3'b000, 5'd5, 5'd7, 13'h40), 32'h60);
        cycle(NOP, 32'h64);
        check("beq_nt_flags", {30'd0, branch, branch_taken}, 32'd2);
        check("beq_nt_target", branch_target, 32'hA0);
        check("beq_nt_valid", {30'd0, state, id_valid}, 32'd1);
        cycle(NOP, 32'h68);
        check("beq_nt_drop", {30'd0, branch, id_valid}, 32'd1);

        // BLT -1 < 1 signed -> taken, +0x10 at 0x100
        cycle(enc_br(3'b100, 5'd8, 5'd9, 13'h10), 32'h100);
        cycle(NOP, 32'h104);
        check("blt_flags", {30'd0, branch, branch_taken}, 32'd3);
        check("blt_target", branch_target, 32'h110);
        cycle(NOP, 32'h108);
        cycle(enc_br(3'b110, 5'd8, 5'd9, 13'h1FF0), 32'h110);
        check("blt_tgt", {id_pc[30:0], id_valid}, {31'h110, 1'b1});
        // BLTU 0xFFFFFFFF < 1 unsigned is false, imm -0x10
        cycle(enc_br(3'b010, 5'd5, 5'd6, 13'h8), 32'h114);
        check("bltu_flags", {30'd0, branch, branch_taken}, 32'd2);
        check("bltu_target", branch_target, 32'h100);
        check("bltu_valid", {31'd0, id_valid}, 32'd1);
        // funct3 010 with equal operands: resolved, never taken
        cycle(NOP, 32'h118);
        check("f3_010_flags", {30'd0, branch, branch_taken}, 32'd2);
        check("f3_010_target", branch_target, 32'h11C);
        check("f3_010_valid", {31'd0, id_valid}, 32'd1);

        // JAL +0x40 at 0x200 then taken BNE: BNE is wrong path
        cycle(enc_jal(21'h40), 32'h200);
        cycle(enc_br(3'b001, 5'd5, 5'd7, 13'h80), 32'h204);
        check("b2b_jal", {30'd0, jal, branch}, 32'd2);
        check("b2b_target", branch_target, 32'h240);
        check("b2b_bne_invalid", {31'd0, id_valid}, 32'd0);
        cycle(NOP, 32'h208);
        check("b2b_no_bne", {29'd0, jal, branch, branch_taken}, 32'd0);
        check("b2b_target_hold", branch_target, 32'h240);
        cycle(NOP, 32'h240);
        check("b2b_tgt", {id_pc[30:0], id_valid}, {31'h240, 1'b1});
        check("b2b_no_late", {30'd0, branch, jal}, 32'd0);

        // Reset during first SQUASH cycle
        cycle(enc_jal(21'h20), 32'h300);
        cycle(NOP, 32'h304);
        check("rs_sq_entry", {30'd0, state, jal}, 32'd3);
        reset = 1'b1;
        cycle(NOP, 32'h308);
        check("rs_pulses", {28'd0, jal, jalr, branch, branch_taken}, 32'd0);
        check("rs_targets", branch_target | jalr_target, 32'd0);
        check("rs_idregs", id_instr | id_pc, 32'd0);
        check("rs_state", {27'd0, state, squash_cnt, id_valid}, 32'd0);
        reset = 1'b0;
        cycle(NOP, 32'h400);
        check("rs_first_valid", {id_pc[30:0], id_valid}, {31'h400, 1'b1});
        check("rs_no_stale", {28'd0, jal, jalr, branch, state}, 32'd0);
        cycle(NOP, 32'h404);
        check("rs_run_on", {28'd0, jal, state, id_valid, branch}, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
